char_normalizer: RTL and testbench
==================================

// Module: char_normalizer
// PURPOSE
//   Input stage ahead of the begin/end block checker. Accepts a raw byte stream
//   over valid/ready, maps it to the checker's alphabet, and buffers it in a FIFO.
//   Mapping: upper-case to lower-case, all whitespace to a single space, NUL removed.
//   The checker advances only on cycles where out_valid && out_ready.
// PARAMETERS
//   DEPTH   8  FIFO entries; must be a power of 2 and >= 2
//   ADDR_W  3  log2(DEPTH)
// PORTS
//   clk        in   1         rising-edge clock; the only clock in the block
//   reset      in   1         synchronous, active-low; sampled on the rising edge of clk
//   in_valid   in   1         upstream byte is valid
//   in_ready   out  1         block can accept a byte this cycle
//   in_data    in   8         raw byte, ASCII
//   out_valid  out  1         out_data holds a valid normalized char
//   out_ready  in   1         downstream consumes out_data this cycle
//   out_data   out  8         normalized char, head of the FIFO
//   dropped    out  1         1-cycle pulse: the previously accepted byte was discarded
//   count      out  ADDR_W+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (reset==0 at a clk edge):
//   - rd_ptr = wr_ptr = 0, count = 0, dropped = 0, last_space = 1.
//   - out_valid = 0 and in_ready = 0 while reset is low; in_ready = 1 in the first
//     cycle after reset is released.
//   - FIFO contents are not cleared; they are don't-care.
//   Accept: a byte is accepted when in_valid && in_ready. in_ready = reset && !full.
//   Map, applied to the accepted byte (combinational):
//   - 0x41..0x5A -> +0x20.
//   - 0x09, 0x0A, 0x0D, 0x20 -> 0x20 (space).
//   - All other bytes pass through unchanged.
//   Discard: the accepted byte is discarded (not written) when:
//   - the raw byte is 0x00, or
//   - the mapped byte is a space and last_space == 1.
//   last_space:
//   - Set to 1 on any accepted space, whether written or discarded.
//   - Cleared to 0 when a non-space byte is written.
//   - A discarded NUL leaves it unchanged.
//   - Consequence: leading whitespace after reset is dropped; runs of whitespace collapse to one space.
//   dropped: registered; high for exactly the cycle after each discarded accept.
//   FIFO:
//   - Pointers are ADDR_W+1 bits wide and wrap modulo 2*DEPTH.
//   - empty = (rd_ptr == wr_ptr).
//   - full = MSBs of rd_ptr and wr_ptr differ and the low ADDR_W bits are equal.
//   - First-word-fall-through: out_valid = !empty; out_data = mem[rd_ptr[ADDR_W-1:0]].
//   - Pop on out_valid && out_ready; rd_ptr increments.
//   - Latency: a byte written at edge N is visible on out_data from edge N onward,
//     so out_valid rises 1 cycle after the accept.
//   Simultaneous events:
//   - Push and pop in the same cycle: count is unchanged.
//   - When full: in_ready = 0 even if a pop happens that cycle; no bypass.
//   - When empty: there is no pop, even if a push happens that cycle.
//   count:
//   - Registered; equals wr_ptr - rd_ptr (mod 2*DEPTH).
//   - Never exceeds DEPTH; never underflows.
//   out_data is don't-care whenever out_valid == 0.
//   Reset asserted mid-operation discards all buffered data; the next output is
//   only data accepted after reset is released.
// TESTING
//   1. out_ready=1; push "BEGIN" one byte per cycle.
//      -> out "begin", each char 1 cycle after its accept; count <= 1; dropped never 1.
//   2. Push "a",0x09,0x0A,0x20,0x20,"b".
//      -> out "a b" (0x61,0x20,0x62); dropped pulses 3 times.
//   3. out_ready=0; push "abcdefghi" (DEPTH=8).
//      -> in_ready=0 after the 8th accept; count=8; 'i' stalls.
//      Then set out_ready=1 -> out "abcdefghi" in order; count returns to 0.
//   4. Immediately after reset, push "  End" with NUL inserted before 'E'.
//      -> out "end"; dropped pulses 3 times.
//   5. Fill to count=5, then hold reset low for 1 cycle.
//      -> count=0, out_valid=0.
//      Then push " x" -> out "x" only.
//   6. Push 40 random bytes with pseudo-random in_valid/out_ready.
//      -> output matches the software model (map + collapse); order preserved across pointer wrap.

Source files
------------

// File: rtl/char_normalizer.sv
// char_normalizer: maps a raw ASCII byte stream onto the block checker's alphabet
// (lower-case letters, single spaces, no NULs) and buffers it in a first-word-fall-through FIFO.
module char_normalizer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              dropped,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned PtrW = ADDR_W + 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              dropped_q, dropped_d;
    logic              last_space_q, last_space_d;

    logic [7:0]        mapped;
    logic              is_space;
    logic              empty, full;
    logic              accept, discard, push, pop;

    // Character mapping of the incoming byte
    always_comb begin
        mapped = in_data;
        if (in_data >= 8'h41 && in_data <= 8'h5A) begin
            mapped = in_data + 8'h20;
        end else if (in_data == 8'h09 || in_data == 8'h0A ||
                     in_data == 8'h0D || in_data == 8'h20) begin
            mapped = 8'h20;
        end
        is_space = (mapped == 8'h20);
    end

    // FIFO status, handshakes and discard decision
    always_comb begin
        empty     = (rd_ptr_q == wr_ptr_q);
        full      = (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]) &&
                    (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]);
        // Both handshakes are gated by reset so nothing moves while it is held low
        in_ready  = reset && !full;
        out_valid = reset && !empty;
        accept    = in_valid && in_ready;
        discard   = accept && ((in_data == 8'h00) || (is_space && last_space_q));
        push      = accept && !discard;
        pop       = out_valid && out_ready;
    end

    // Next-state for pointers, occupancy, drop pulse and whitespace tracking
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d      = wr_ptr_d - rd_ptr_d;
        dropped_d    = discard;
        last_space_d = last_space_q;
        if (accept && is_space) begin
            last_space_d = 1'b1;
        end else if (push) begin
            last_space_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dropped_q    <= 1'b0;
            last_space_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dropped_q    <= dropped_d;
            last_space_q <= last_space_d;
        end
    end

    // Storage array; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= mapped;
        end
    end

    // Output drive
    always_comb begin
        out_data = mem[rd_ptr_q[ADDR_W-1:0]];
        dropped  = dropped_q;
        count    = count_q;
    end

endmodule

// File: tb/tb_char_normalizer.sv
// Testbench for char_normalizer: table-driven mapping vectors, directed corner sequences and a
// scoreboard fed from a reference model on every accepted byte.
module tb_char_normalizer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data   = 8'h00;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        out_data;
    logic              dropped;
    logic [ADDR_W:0]   count;

    int errors = 0;
    int checks = 0;

    byte unsigned sb[$];
    bit           ls        = 1'b1;
    bit           exp_drop  = 1'b0;
    int           drop_cnt  = 0;
    int           pushed    = 0;
    int           popped    = 0;
    int           max_count = 0;
    string        got       = "";

    typedef struct {
        byte unsigned din;
        byte unsigned dout;
        bit           drop;
    } vec_t;

    vec_t tbl [17];

    char_normalizer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dropped   (dropped),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
        end
    endtask

    function automatic byte unsigned map_char(input byte unsigned b);
        if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        if (b == 8'h09 || b == 8'h0A || b == 8'h0D || b == 8'h20) return 8'h20;
        return b;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle for the upcoming edge
    always @(negedge clk) begin
        bit           acc;
        bit           pop;
        byte unsigned m;
        byte unsigned e;
        chk("count", int'(count), sb.size());
        chk("out_valid", int'(out_valid), int'(reset && sb.size() != 0));
        chk("in_ready", int'(in_ready), int'(reset && sb.size() < DEPTH));
        chk("dropped", int'(dropped), int'(exp_drop));
        if (dropped) drop_cnt++;
        if (int'(count) > max_count) max_count = int'(count);
        acc      = in_valid && reset && (sb.size() < DEPTH);
        pop      = reset && (sb.size() != 0) && out_ready;
        exp_drop = 1'b0;
        if (pop) begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), int'(e));
            got = $sformatf("%s%c", got, out_data);
            popped++;
        end
        if (acc) begin
            m = map_char(in_data);
            if (in_data == 8'h00 || (m == 8'h20 && ls)) begin
                exp_drop = 1'b1;
            end else begin
                sb.push_back(m);
                pushed++;
            end
            if (m == 8'h20) ls = 1'b1;
            else if (!exp_drop) ls = 1'b0;
        end
        if (!reset) begin
            sb.delete();
            ls       = 1'b1;
            exp_drop = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the byte on the bus until accepted; leaves in_valid high for back-to-back sends
    task automatic send(input byte unsigned b);
        bit acc;
        int n;
        acc      = 1'b0;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        do begin
            tick();
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 200);
        if (n >= 200) chk("drain_timeout", 0, 1);
        tick();
    endtask

    function automatic byte unsigned rand_byte();
        case ($urandom_range(7))
            0:       return 8'h00;
            1:       return 8'h20;
            2:       return 8'h09;
            3:       return 8'h0A;
            4:       return 8'h41 + 8'($urandom_range(25));
            5:       return 8'h61 + 8'($urandom_range(25));
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        int q0;

        tbl = '{
            '{8'h41, 8'h61, 1'b0}, '{8'h5A, 8'h7A, 1'b0}, '{8'h40, 8'h40, 1'b0},
            '{8'h5B, 8'h5B, 1'b0}, '{8'h09, 8'h20, 1'b0}, '{8'h0D, 8'h00, 1'b1},
            '{8'h20, 8'h00, 1'b1}, '{8'h61, 8'h61, 1'b0}, '{8'h00, 8'h00, 1'b1},
            '{8'h0A, 8'h20, 1'b0}, '{8'h00, 8'h00, 1'b1}, '{8'h0D, 8'h00, 1'b1},
            '{8'h0B, 8'h0B, 1'b0}, '{8'hC1, 8'hC1, 1'b0}, '{8'h60, 8'h60, 1'b0},
            '{8'h7B, 8'h7B, 1'b0}, '{8'h20, 8'h20, 1'b1 ^ 1'b1}
        };

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_dropped", int'(dropped), 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);
        tick();

        // Leading whitespace and NUL dropped right after reset
        got = ""; drop_cnt = 0; out_ready = 1'b1;
        send(8'h20); send(8'h20); send(8'h00);
        send_str("End");
        drain();
        chk_str("lead_ws", got, "end");
        chk("lead_ws_drops", drop_cnt, 3);

        // Back-to-back stream with a consumer that is always ready
        got = ""; drop_cnt = 0; max_count = 0;
        send_str("BEGIN");
        drain();
        chk_str("begin", got, "begin");
        chk("begin_drops", drop_cnt, 0);
        chk("begin_max_count", int'(max_count <= 1), 1);

        // Single-byte mapping table
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            in_data  = tbl[i].din;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_drop", i), int'(dropped), int'(tbl[i].drop));
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(!tbl[i].drop));
            if (!tbl[i].drop) chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].dout));
            tick();
        end

        // Whitespace run collapse
        got = ""; drop_cnt = 0;
        send_str("a\t\n  b");
        drain();
        chk_str("collapse", got, "a b");
        chk("collapse_drops", drop_cnt, 3);

        // Fill to full with a stalled consumer, then release
        got = ""; out_ready = 1'b0;
        send_str("abcdefgh");
        in_data  = 8'h69;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_count", int'(count), 8);
            tick();
        end
        out_ready = 1'b1;
        send(8'h69);
        in_valid = 1'b0;
        drain();
        chk_str("full_order", got, "abcdefghi");
        chk("full_count_empty", int'(count), 0);

        // Reset mid-operation discards buffered data
        out_ready = 1'b0;
        send_str("hello");
        @(negedge clk);
        chk("pre_reset_count", int'(count), 5);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_count", int'(count), 0);
        chk("mid_reset_out_valid", int'(out_valid), 0);
        tick();
        got = "";
        send_str(" x");
        drain();
        chk_str("after_reset", got, "x");

        // Random traffic with random valid/ready across pointer wrap
        p0 = pushed; q0 = popped;
        for (int i = 0; i < 40; i++) begin
            bit acc;
            int n;
            acc     = 1'b0;
            n       = 0;
            in_data = rand_byte();
            while (!acc && n < 200) begin
                in_valid  = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(1) != 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                tick();
                n++;
            end
            if (!acc) chk("rand_timeout", 0, 1);
        end
        in_valid = 1'b0;
        drain();
        chk("rand_all_out", popped - q0, pushed - p0);
        chk("rand_final_count", int'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
